// File: rtl/axi_pkg.sv
// Shared AXI definitions: burst and response encodings, FSM states, beat address stepping.
// Latency: none (types, constants and a pure function).
// Backpressure: not applicable.
package axi_pkg;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {
        W_IDLE,
        W_DATA,
        W_RESP
    } w_state_t;

    typedef enum logic {
        R_IDLE,
        R_DATA
    } r_state_t;

    // Address of the beat following 'addr'. Works on a 32-bit container; callers
    // truncate to their own address width, which gives INCR its modulo wrap.
    // WRAP stays inside the window of (len+1) beats aligned to its own size.
    function automatic logic [31:0] axi_next_addr(
        input logic [31:0] addr,
        input logic [2:0]  size,
        input logic [7:0]  len,
        input logic [1:0]  burst
    );
        logic [31:0] step;
        logic [31:0] bytes;
        logic [31:0] mask;
        step  = 32'd1 << size;
        bytes = ({24'd0, len} + 32'd1) << size;
        mask  = bytes - 32'd1;
        case (burst)
            BURST_INCR: return addr + step;
            BURST_WRAP: return (addr & ~mask) | ((addr + step) & mask);
            default:    return addr;
        endcase
    endfunction

endpackage

// File: rtl/axi_dut_mem_if.sv
// AXI4 bus bundle (AW, W, B, AR, R channels) with master and slave views.
// Latency: none (wires only).
// Backpressure: carried by the per-channel VALID/READY pairs.
interface axi_dut_mem_if #(
    parameter int ADDR_WIDTH   = 16,
    parameter int DATA_WIDTH   = 32,
    parameter int LEN_WIDTH    = 8,
    parameter int SIZE_WIDTH   = 3,
    parameter int BURST_WIDTH  = 2,
    parameter int RESP_WIDTH   = 2,
    parameter int ID_WIDTH     = 4,
    parameter int STROBE_WIDTH = DATA_WIDTH / 8
);
    logic                    AWVALID;
    logic                    AWREADY;
    logic [ID_WIDTH-1:0]     AWID;
    logic [ADDR_WIDTH-1:0]   AWADDR;
    logic [LEN_WIDTH-1:0]    AWLEN;
    logic [SIZE_WIDTH-1:0]   AWSIZE;
    logic [BURST_WIDTH-1:0]  AWBURST;

    logic                    WVALID;
    logic                    WREADY;
    logic [DATA_WIDTH-1:0]   WDATA;
    logic [STROBE_WIDTH-1:0] WSTRB;
    logic                    WLAST;

    logic                    BVALID;
    logic                    BREADY;
    logic [ID_WIDTH-1:0]     BID;
    logic [RESP_WIDTH-1:0]   BRESP;

    logic                    ARVALID;
    logic                    ARREADY;
    logic [ID_WIDTH-1:0]     ARID;
    logic [ADDR_WIDTH-1:0]   ARADDR;
    logic [LEN_WIDTH-1:0]    ARLEN;
    logic [SIZE_WIDTH-1:0]   ARSIZE;
    logic [BURST_WIDTH-1:0]  ARBURST;

    logic                    RVALID;
    logic                    RREADY;
    logic [ID_WIDTH-1:0]     RID;
    logic [DATA_WIDTH-1:0]   RDATA;
    logic [RESP_WIDTH-1:0]   RRESP;
    logic                    RLAST;

    modport slave (
        input  AWVALID, AWID, AWADDR, AWLEN, AWSIZE, AWBURST,
        output AWREADY,
        input  WVALID, WDATA, WSTRB, WLAST,
        output WREADY,
        output BVALID, BID, BRESP,
        input  BREADY,
        input  ARVALID, ARID, ARADDR, ARLEN, ARSIZE, ARBURST,
        output ARREADY,
        output RVALID, RID, RDATA, RRESP, RLAST,
        input  RREADY
    );

    modport master (
        output AWVALID, AWID, AWADDR, AWLEN, AWSIZE, AWBURST,
        input  AWREADY,
        output WVALID, WDATA, WSTRB, WLAST,
        input  WREADY,
        input  BVALID, BID, BRESP,
        output BREADY,
        output ARVALID, ARID, ARADDR, ARLEN, ARSIZE, ARBURST,
        input  ARREADY,
        input  RVALID, RID, RDATA, RRESP, RLAST,
        output RREADY
    );

endinterface

// File: rtl/axi_mem_ram.sv
// Word-organised RAM with a byte-enabled write port and a registered read port.
// Latency: read data one cycle after re; a same-cycle write to that word is not seen.
// Backpressure: none; read data holds while re is low.
module axi_mem_ram #(
    parameter int IDX_W        = 14,
    parameter int DATA_WIDTH   = 32,
    parameter int STROBE_WIDTH = DATA_WIDTH / 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    we,
    input  logic [IDX_W-1:0]        waddr,
    input  logic [DATA_WIDTH-1:0]   wdata,
    input  logic [STROBE_WIDTH-1:0] wstrb,
    input  logic                    re,
    input  logic [IDX_W-1:0]        raddr,
    output logic [DATA_WIDTH-1:0]   rdata
);

    logic [DATA_WIDTH-1:0] mem [0:(1<<IDX_W)-1];

    // Byte-lane write; storage is deliberately not touched by reset.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < STROBE_WIDTH; i++) begin
                if (wstrb[i]) begin
                    mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
    end

    // Registered read, held between enables so an unaccepted beat stays stable.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/axi_dut_mem.sv
// AXI4 slave over on-chip memory: one write and one read burst in flight, FIXED/INCR/WRAP.
// Latency: first read beat one cycle after AR handshake; B one cycle after the WLAST beat.
// Backpressure: RDATA/RLAST and BID/BRESP hold until RREADY/BREADY; AWREADY/ARREADY low while busy.
module axi_dut_mem
    import axi_pkg::*;
#(
    parameter int ADDR_WIDTH     = 16,
    parameter int DATA_WIDTH     = 32,
    parameter int LEN_WIDTH      = 8,
    parameter int SIZE_WIDTH     = 3,
    parameter int BURST_WIDTH    = 2,
    parameter int RESP_WIDTH     = 2,
    parameter int ID_WIDTH       = 4,
    parameter int STROBE_WIDTH   = DATA_WIDTH / 8,
    parameter int ADDR_BYTE_SIZE = 1
) (
    input  logic         axi_ACLK,
    input  logic         axi_ARESET,
    axi_dut_mem_if.slave axi
);

    localparam int LANE_SHIFT = $clog2(STROBE_WIDTH / ADDR_BYTE_SIZE);
    localparam int IDX_W      = ADDR_WIDTH - LANE_SHIFT;
    localparam int MAX_SIZE   = $clog2(STROBE_WIDTH);

    // Oversized beats and the reserved burst type get SLVERR.
    function automatic logic bad_req(input logic [SIZE_WIDTH-1:0] sz,
                                     input logic [BURST_WIDTH-1:0] bt);
        return (int'(sz) > MAX_SIZE) || (bt == {BURST_WIDTH{1'b1}});
    endfunction

    // ---------------- write channel state ----------------
    w_state_t               w_state;
    logic [ID_WIDTH-1:0]    w_id;
    logic [ADDR_WIDTH-1:0]  w_addr;
    logic [LEN_WIDTH-1:0]   w_len;
    logic [SIZE_WIDTH-1:0]  w_size;
    logic [BURST_WIDTH-1:0] w_burst;
    logic                   w_err;
    logic [LEN_WIDTH:0]     w_cnt;      // one spare bit so over-long bursts never alias
    logic [ADDR_WIDTH-1:0]  w_next_addr;

    // ---------------- read channel state ----------------
    r_state_t               r_state;
    logic [ADDR_WIDTH-1:0]  r_addr;
    logic [LEN_WIDTH-1:0]   r_len;
    logic [SIZE_WIDTH-1:0]  r_size;
    logic [BURST_WIDTH-1:0] r_burst;
    logic                   r_err;
    logic [LEN_WIDTH-1:0]   r_cnt;
    logic [ADDR_WIDTH-1:0]  r_next_addr;

    // ---------------- RAM hookup ----------------
    logic                   ram_we;
    logic                   ram_re;
    logic [IDX_W-1:0]       ram_raddr;
    logic [DATA_WIDTH-1:0]  ram_q;

    assign w_next_addr = ADDR_WIDTH'(axi_next_addr(32'(w_addr), 3'(w_size), 8'(w_len), 2'(w_burst)));
    assign r_next_addr = ADDR_WIDTH'(axi_next_addr(32'(r_addr), 3'(r_size), 8'(r_len), 2'(r_burst)));

    // Beats past AWLEN+1 and errored bursts are accepted but never reach memory.
    assign ram_we = (w_state == W_DATA) && axi.WVALID && axi.WREADY && !w_err
                    && (w_cnt <= {1'b0, w_len});

    // Fetch the first beat on the AR handshake and each following beat on the
    // previous beat's handshake, so data is always one cycle ahead of RVALID.
    assign ram_re = ((r_state == R_IDLE) && axi.ARVALID && axi.ARREADY)
                 || ((r_state == R_DATA) && axi.RVALID && axi.RREADY && !axi.RLAST);
    assign ram_raddr = (r_state == R_IDLE) ? axi.ARADDR[ADDR_WIDTH-1:LANE_SHIFT]
                                           : r_next_addr[ADDR_WIDTH-1:LANE_SHIFT];

    axi_mem_ram #(
        .IDX_W        (IDX_W),
        .DATA_WIDTH   (DATA_WIDTH),
        .STROBE_WIDTH (STROBE_WIDTH)
    ) u_ram (
        .clk   (axi_ACLK),
        .rst   (axi_ARESET),
        .we    (ram_we),
        .waddr (w_addr[ADDR_WIDTH-1:LANE_SHIFT]),
        .wdata (axi.WDATA),
        .wstrb (axi.WSTRB),
        .re    (ram_re),
        .raddr (ram_raddr),
        .rdata (ram_q)
    );

    // Errored reads return zeros on every beat.
    assign axi.RDATA = r_err ? '0 : ram_q;

    // Write FSM: AW accept, data beats until WLAST, then hold B until accepted.
    always_ff @(posedge axi_ACLK) begin
        if (axi_ARESET) begin
            w_state     <= W_IDLE;
            axi.AWREADY <= 1'b0;
            axi.WREADY  <= 1'b0;
            axi.BVALID  <= 1'b0;
            axi.BID     <= '0;
            axi.BRESP   <= '0;
            w_id        <= '0;
            w_addr      <= '0;
            w_len       <= '0;
            w_size      <= '0;
            w_burst     <= '0;
            w_err       <= 1'b0;
            w_cnt       <= '0;
        end else begin
            case (w_state)
                W_IDLE: begin
                    if (axi.AWVALID && axi.AWREADY) begin
                        w_id        <= axi.AWID;
                        w_addr      <= axi.AWADDR;
                        w_len       <= axi.AWLEN;
                        w_size      <= axi.AWSIZE;
                        w_burst     <= axi.AWBURST;
                        w_err       <= bad_req(axi.AWSIZE, axi.AWBURST);
                        w_cnt       <= '0;
                        axi.AWREADY <= 1'b0;
                        axi.WREADY  <= 1'b1;
                        w_state     <= W_DATA;
                    end else begin
                        axi.AWREADY <= 1'b1;
                    end
                end
                W_DATA: begin
                    if (axi.WVALID) begin
                        w_addr <= w_next_addr;
                        if (w_cnt != '1) begin
                            w_cnt <= w_cnt + (LEN_WIDTH+1)'(1);
                        end
                        if (axi.WLAST) begin
                            axi.WREADY <= 1'b0;
                            axi.BVALID <= 1'b1;
                            axi.BID    <= w_id;
                            axi.BRESP  <= w_err ? RESP_WIDTH'(RESP_SLVERR) : RESP_WIDTH'(RESP_OKAY);
                            w_state    <= W_RESP;
                        end
                    end
                end
                W_RESP: begin
                    if (axi.BREADY) begin
                        axi.BVALID  <= 1'b0;
                        axi.AWREADY <= 1'b1;
                        w_state     <= W_IDLE;
                    end
                end
                default: w_state <= W_IDLE;
            endcase
        end
    end

    // Read FSM: AR accept, then stream LEN+1 beats, each held until RREADY.
    always_ff @(posedge axi_ACLK) begin
        if (axi_ARESET) begin
            r_state     <= R_IDLE;
            axi.ARREADY <= 1'b0;
            axi.RVALID  <= 1'b0;
            axi.RLAST   <= 1'b0;
            axi.RID     <= '0;
            axi.RRESP   <= '0;
            r_addr      <= '0;
            r_len       <= '0;
            r_size      <= '0;
            r_burst     <= '0;
            r_err       <= 1'b0;
            r_cnt       <= '0;
        end else begin
            case (r_state)
                R_IDLE: begin
                    if (axi.ARVALID && axi.ARREADY) begin
                        r_addr      <= axi.ARADDR;
                        r_len       <= axi.ARLEN;
                        r_size      <= axi.ARSIZE;
                        r_burst     <= axi.ARBURST;
                        r_err       <= bad_req(axi.ARSIZE, axi.ARBURST);
                        r_cnt       <= '0;
                        axi.ARREADY <= 1'b0;
                        axi.RVALID  <= 1'b1;
                        axi.RLAST   <= (axi.ARLEN == '0);
                        axi.RID     <= axi.ARID;
                        axi.RRESP   <= bad_req(axi.ARSIZE, axi.ARBURST) ? RESP_WIDTH'(RESP_SLVERR)
                                                                        : RESP_WIDTH'(RESP_OKAY);
                        r_state     <= R_DATA;
                    end else begin
                        axi.ARREADY <= 1'b1;
                    end
                end
                R_DATA: begin
                    if (axi.RREADY) begin
                        if (axi.RLAST) begin
                            axi.RVALID  <= 1'b0;
                            axi.RLAST   <= 1'b0;
                            axi.ARREADY <= 1'b1;
                            r_state     <= R_IDLE;
                        end else begin
                            r_addr    <= r_next_addr;
                            r_cnt     <= r_cnt + LEN_WIDTH'(1);
                            axi.RLAST <= ((r_cnt + LEN_WIDTH'(1)) == r_len);
                        end
                    end
                end
                default: r_state <= R_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_dut_mem.sv
// Directed + randomized bench for axi_dut_mem against a byte-array reference model.
// Latency: checks first-beat, B and ready timing cycle by cycle.
// Backpressure: exercises BREADY/RREADY stalls and idle WVALID gaps.
module tb_axi_dut_mem;

    logic axi_tb_ACLK;
    logic axi_tb_ARESET;

    axi_dut_mem_if bus ();

    axi_dut_mem dut (
        .axi_ACLK   (axi_tb_ACLK),
        .axi_ARESET (axi_tb_ARESET),
        .axi        (bus)
    );

    initial axi_tb_ACLK = 1'b0;
    always #5 axi_tb_ACLK = ~axi_tb_ACLK;

    int checks;
    int errors;

    // Reference memory: one byte per address, plus a written flag.
    logic [7:0] mem_b [0:65535];
    bit         known [0:65535];

    logic [31:0] wbuf [0:15];
    logic [3:0]  sbuf [0:15];
    logic [31:0] last_rd;
    logic [31:0] saved;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Byte address of beat i of a burst, straight from the burst rules.
    function automatic int unsigned beat_addr(input int unsigned a, input int i,
                                              input int len, input int size, input int burst);
        int unsigned step;
        int unsigned bytes;
        int unsigned base;
        step  = 1 << size;
        bytes = (len + 1) * step;
        case (burst)
            1:       return (a + i * step) % 65536;
            2: begin
                base = a - (a % bytes);
                return base + ((a - base + i * step) % bytes);
            end
            default: return a;
        endcase
    endfunction

    function automatic logic [31:0] model_word(input int unsigned a);
        int unsigned w;
        w = (a % 65536) / 4;
        return {mem_b[w*4+3], mem_b[w*4+2], mem_b[w*4+1], mem_b[w*4]};
    endfunction

    task automatic axi_write(input logic [3:0] id, input int unsigned addr, input int len,
                             input int size, input int burst, input int nbeats);
        int  t;
        bit  err;
        int unsigned w;
        logic [31:0] d;
        err = (size > 2) || (burst == 3);
        bus.AWID    = id;
        bus.AWADDR  = 16'(addr);
        bus.AWLEN   = 8'(len);
        bus.AWSIZE  = 3'(size);
        bus.AWBURST = 2'(burst);
        bus.AWVALID = 1'b1;
        t = 0;
        while (bus.AWREADY !== 1'b1 && t < 200) begin @(negedge axi_tb_ACLK); t++; end
        if (t >= 200) chk("aw_timeout", 64'(bus.AWREADY), 64'd1);
        @(negedge axi_tb_ACLK);
        bus.AWVALID = 1'b0;
        chk("aw_busy", 64'(bus.AWREADY), 64'd0);
        chk("wready_up", 64'(bus.WREADY), 64'd1);
        for (int i = 0; i < nbeats; i++) begin
            if ($urandom_range(0, 3) == 0) @(negedge axi_tb_ACLK);
            bus.WDATA  = wbuf[i];
            bus.WSTRB  = sbuf[i];
            bus.WLAST  = (i == nbeats - 1);
            bus.WVALID = 1'b1;
            t = 0;
            while (bus.WREADY !== 1'b1 && t < 200) begin @(negedge axi_tb_ACLK); t++; end
            if (t >= 200) chk("w_timeout", 64'(bus.WREADY), 64'd1);
            @(negedge axi_tb_ACLK);
            bus.WVALID = 1'b0;
            bus.WLAST  = 1'b0;
        end
        chk("bvalid_up", 64'(bus.BVALID), 64'd1);
        chk("wready_down", 64'(bus.WREADY), 64'd0);
        chk("bid", 64'(bus.BID), 64'(id));
        chk("bresp", 64'(bus.BRESP), err ? 64'd2 : 64'd0);
        @(negedge axi_tb_ACLK);
        chk("bvalid_hold", 64'(bus.BVALID), 64'd1);
        chk("bid_hold", 64'(bus.BID), 64'(id));
        bus.BREADY = 1'b1;
        @(negedge axi_tb_ACLK);
        bus.BREADY = 1'b0;
        chk("bvalid_down", 64'(bus.BVALID), 64'd0);
        chk("awready_back", 64'(bus.AWREADY), 64'd1);
        if (!err) begin
            for (int i = 0; i < nbeats && i <= len; i++) begin
                w = beat_addr(addr, i, len, size, burst) / 4;
                d = wbuf[i];
                for (int l = 0; l < 4; l++) begin
                    if (sbuf[i][l]) begin
                        mem_b[w*4+l] = d[8*l +: 8];
                        known[w*4+l] = 1'b1;
                    end
                end
            end
        end
    endtask

    task automatic axi_read(input logic [3:0] id, input int unsigned addr, input int len,
                            input int size, input int burst, input int stall_beat,
                            output logic [31:0] last);
        int  t;
        bit  err;
        logic [31:0] exp;
        err = (size > 2) || (burst == 3);
        last = '0;
        bus.ARID    = id;
        bus.ARADDR  = 16'(addr);
        bus.ARLEN   = 8'(len);
        bus.ARSIZE  = 3'(size);
        bus.ARBURST = 2'(burst);
        bus.ARVALID = 1'b1;
        t = 0;
        while (bus.ARREADY !== 1'b1 && t < 200) begin @(negedge axi_tb_ACLK); t++; end
        if (t >= 200) chk("ar_timeout", 64'(bus.ARREADY), 64'd1);
        @(negedge axi_tb_ACLK);
        bus.ARVALID = 1'b0;
        chk("ar_busy", 64'(bus.ARREADY), 64'd0);
        for (int i = 0; i <= len; i++) begin
            exp = err ? 32'd0 : model_word(beat_addr(addr, i, len, size, burst));
            chk($sformatf("rvalid_b%0d", i), 64'(bus.RVALID), 64'd1);
            chk($sformatf("rdata_b%0d", i), 64'(bus.RDATA), 64'(exp));
            chk($sformatf("rlast_b%0d", i), 64'(bus.RLAST), 64'(i == len));
            chk($sformatf("rresp_b%0d", i), 64'(bus.RRESP), err ? 64'd2 : 64'd0);
            chk($sformatf("rid_b%0d", i), 64'(bus.RID), 64'(id));
            last = bus.RDATA;
            if (i == stall_beat) begin
                repeat (3) begin
                    @(negedge axi_tb_ACLK);
                    chk("stall_rvalid", 64'(bus.RVALID), 64'd1);
                    chk("stall_rdata", 64'(bus.RDATA), 64'(exp));
                    chk("stall_rlast", 64'(bus.RLAST), 64'(i == len));
                end
            end
            bus.RREADY = 1'b1;
            @(negedge axi_tb_ACLK);
            bus.RREADY = 1'b0;
        end
        chk("rvalid_down", 64'(bus.RVALID), 64'd0);
        chk("rlast_down", 64'(bus.RLAST), 64'd0);
        chk("arready_back", 64'(bus.ARREADY), 64'd1);
    endtask

    task automatic fill_rand(input int n);
        for (int i = 0; i < n; i++) begin
            wbuf[i] = $urandom;
            sbuf[i] = 4'hF;
        end
    endtask

    initial begin
        #5000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned a;
        int ln;
        int bt;
        int lens [4];
        lens = '{1, 3, 7, 15};
        checks = 0;
        errors = 0;
        for (int i = 0; i < 65536; i++) known[i] = 1'b0;

        axi_tb_ARESET = 1'b1;
        bus.AWVALID = 0; bus.AWID = 0; bus.AWADDR = 0; bus.AWLEN = 0; bus.AWSIZE = 0; bus.AWBURST = 0;
        bus.WVALID = 0;  bus.WDATA = 0; bus.WSTRB = 0; bus.WLAST = 0; bus.BREADY = 0;
        bus.ARVALID = 0; bus.ARID = 0; bus.ARADDR = 0; bus.ARLEN = 0; bus.ARSIZE = 0; bus.ARBURST = 0;
        bus.RREADY = 0;
        repeat (10) @(negedge axi_tb_ACLK);

        // Outputs under reset.
        chk("rst_awready", 64'(bus.AWREADY), 64'd0);
        chk("rst_wready",  64'(bus.WREADY),  64'd0);
        chk("rst_bvalid",  64'(bus.BVALID),  64'd0);
        chk("rst_arready", 64'(bus.ARREADY), 64'd0);
        chk("rst_rvalid",  64'(bus.RVALID),  64'd0);
        chk("rst_rlast",   64'(bus.RLAST),   64'd0);
        chk("rst_bid_bresp", 64'({bus.BID, bus.BRESP}), 64'd0);
        chk("rst_rid_rresp", 64'({bus.RID, bus.RRESP}), 64'd0);
        chk("rst_rdata",   64'(bus.RDATA),   64'd0);
        axi_tb_ARESET = 1'b0;
        @(negedge axi_tb_ACLK);
        chk("post_rst_awready", 64'(bus.AWREADY), 64'd1);
        chk("post_rst_arready", 64'(bus.ARREADY), 64'd1);

        // INCR round trips, including the top of the address space.
        fill_rand(8);
        axi_write(4'hA, 32'h0000, 7, 2, 1, 8);
        axi_read(4'hA, 32'h0000, 7, 2, 1, -1, last_rd);
        fill_rand(8); axi_write(4'h3, 32'h00F0, 7, 2, 1, 8); axi_read(4'h3, 32'h00F0, 7, 2, 1, -1, last_rd);
        fill_rand(8); axi_write(4'h5, 32'h7FF8, 7, 2, 1, 8); axi_read(4'h5, 32'h7FF8, 7, 2, 1, -1, last_rd);
        fill_rand(8); axi_write(4'h6, 32'hFFE0, 7, 2, 1, 8); axi_read(4'h6, 32'hFFE0, 7, 2, 1, -1, last_rd);

        // INCR wrapping past 0xFFFC into 0x0000.
        fill_rand(4);
        saved = wbuf[3];
        axi_write(4'h7, 32'hFFF8, 3, 2, 1, 4);
        axi_read(4'h7, 32'hFFF8, 3, 2, 1, -1, last_rd);
        axi_read(4'h8, 32'h0000, 1, 2, 1, -1, last_rd);
        chk("incr_wrap_lands_at_4", 64'(last_rd), 64'(saved));

        // Byte strobes: lanes 0 and 2 only over an all-ones word.
        wbuf[0] = 32'hFFFF_FFFF; sbuf[0] = 4'hF;
        axi_write(4'h1, 32'h0100, 0, 2, 1, 1);
        wbuf[0] = 32'h1234_5678; sbuf[0] = 4'b0101;
        axi_write(4'h2, 32'h0100, 0, 2, 1, 1);
        axi_read(4'h2, 32'h0100, 0, 2, 1, -1, last_rd);
        chk("strobe_lanes", 64'(last_rd), 64'h0000_0000_FF34_FF78);

        // WRAP: 0x18,0x1C,0x10,0x14; verify through an INCR read of the window.
        fill_rand(4);
        saved = wbuf[2];
        axi_write(4'h4, 32'h0018, 3, 2, 2, 4);
        axi_read(4'h4, 32'h0018, 3, 2, 2, -1, last_rd);
        axi_read(4'h9, 32'h0010, 0, 2, 1, -1, last_rd);
        chk("wrap_third_beat_at_10", 64'(last_rd), 64'(saved));

        // FIXED: every beat hits one word, last one wins.
        fill_rand(4);
        saved = wbuf[3];
        axi_write(4'hB, 32'h0200, 3, 2, 0, 4);
        axi_read(4'hB, 32'h0200, 0, 2, 1, -1, last_rd);
        chk("fixed_last_wins", 64'(last_rd), 64'(saved));

        // Extra beats beyond AWLEN+1 are dropped.
        fill_rand(4); axi_write(4'hC, 32'h0300, 3, 2, 1, 4);
        fill_rand(4); axi_write(4'hC, 32'h0300, 1, 2, 1, 4);
        axi_read(4'hC, 32'h0300, 3, 2, 1, -1, last_rd);

        // Error requests: SLVERR, memory untouched, errored reads return zero.
        fill_rand(2); axi_write(4'hD, 32'h0000, 1, 3, 1, 2);
        axi_read(4'hD, 32'h0000, 1, 2, 1, -1, last_rd);
        fill_rand(2); axi_write(4'hE, 32'h00F0, 1, 2, 3, 2);
        axi_read(4'hE, 32'h00F0, 1, 2, 1, -1, last_rd);
        axi_read(4'hF, 32'h0000, 1, 3, 1, -1, last_rd);
        axi_read(4'h1, 32'h00F0, 1, 2, 3, -1, last_rd);

        // RREADY held low for three cycles mid-burst.
        axi_read(4'h2, 32'h0000, 7, 2, 1, 3, last_rd);

        // Randomized INCR/WRAP bursts.
        for (int k = 0; k < 8; k++) begin
            bt = $urandom_range(1, 2);
            ln = (bt == 2) ? lens[$urandom_range(0, 3)] : int'($urandom_range(0, 15));
            a  = $urandom_range(16'h1000, 16'hEFFF) & 32'hFFFC;
            fill_rand(ln + 1);
            for (int i = 0; i <= ln; i++) sbuf[i] = 4'($urandom_range(1, 15));
            axi_write(4'($urandom), a, ln, 2, bt, ln + 1);
            axi_read(4'($urandom), a, ln, 2, bt, int'($urandom_range(0, 16)), last_rd);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/axi_dut_mem.md
# axi_dut_mem

AXI4 full-protocol slave backed by an on-chip byte-addressable memory. Accepts single-outstanding write and read bursts (FIXED/INCR/WRAP) on independent channels, stores data with byte-strobe masking, and returns it on reads. Serves as the memory-mapped endpoint under test on the AXI fabric.

## Interface
Parameters:
- ADDR_WIDTH, 16, byte-address width; memory size is 2^ADDR_WIDTH bytes
- DATA_WIDTH, 32, data bus width
- LEN_WIDTH, 8, AxLEN width
- SIZE_WIDTH, 3, AxSIZE width
- BURST_WIDTH, 2, AxBURST width
- RESP_WIDTH, 2, xRESP width
- ID_WIDTH, 4, transaction ID width
- STROBE_WIDTH, DATA_WIDTH/8, WSTRB width
- ADDR_BYTE_SIZE, 1, bytes per address unit

Ports (one clock; reset is synchronous and active-high):
- axi_ACLK  in  1  clock, all logic on rising edge
- axi_ARESET  in  1  synchronous active-high reset
- axi_AWVALID/axi_AWREADY  in/out  1  write-address handshake
- axi_AWID  in  ID_WIDTH;  axi_AWADDR  in  ADDR_WIDTH;  axi_AWLEN  in  LEN_WIDTH (beats-1);  axi_AWSIZE  in  SIZE_WIDTH (2^n bytes/beat);  axi_AWBURST  in  BURST_WIDTH
- axi_WVALID/axi_WREADY  in/out  1;  axi_WDATA  in  DATA_WIDTH;  axi_WSTRB  in  STROBE_WIDTH;  axi_WLAST  in  1
- axi_BVALID  out  1;  axi_BREADY  in  1;  axi_BID  out  ID_WIDTH;  axi_BRESP  out  RESP_WIDTH
- axi_ARVALID/axi_ARREADY  in/out  1;  axi_ARID, axi_ARADDR, axi_ARLEN, axi_ARSIZE, axi_ARBURST  in  as AW
- axi_RVALID  out  1;  axi_RREADY  in  1;  axi_RID  out  ID_WIDTH;  axi_RDATA  out  DATA_WIDTH;  axi_RRESP  out  RESP_WIDTH;  axi_RLAST  out  1

## Operation
- Memory: 2^ADDR_WIDTH/STROBE_WIDTH words of DATA_WIDTH; word index = addr >> log2(STROBE_WIDTH/ADDR_BYTE_SIZE). Contents not cleared by reset.
- Write FSM: W_IDLE (AWREADY=1) -> AW handshake latches ID/addr/len/size/burst -> W_DATA (WREADY=1) -> each WVALID&WREADY writes enabled byte lanes (WSTRB[i] -> bits 8i+7:8i) at current word, then advances address -> beat with WLAST=1 -> W_RESP (BVALID=1, BID=latched AWID) -> BVALID&BREADY -> W_IDLE.
- Read FSM: R_IDLE (ARREADY=1) -> AR handshake -> R_DATA: RVALID=1, RID=ARID, RDATA=word at current address; each RVALID&RREADY advances; RLAST=1 on beat ARLEN (ARLEN+1 beats total) -> after last handshake R_IDLE.
- Address update per beat: FIXED unchanged; INCR +2^SIZE, wraps modulo 2^ADDR_WIDTH; WRAP +2^SIZE within aligned window of (LEN+1)*2^SIZE bytes.
- Responses: OKAY (00) normally; SLVERR (10) when AxSIZE > log2(STROBE_WIDTH) or AxBURST=11 -- writes then suppressed, reads return 0 with SLVERR on every beat; burst still completes normally.
- Write data beats beyond AWLEN+1 before WLAST are ignored (no memory write); WLAST terminates regardless of count.
- Read and write channels fully independent; concurrent same-word read/write: read returns pre-write data.

## Timing
- Reset: all outputs 0 (AWREADY, WREADY, BVALID, ARREADY, RVALID, RLAST, IDs, RESP, RDATA); FSMs to idle. First cycle after release: AWREADY=ARREADY=1. Reset mid-burst aborts; already-written words persist.
- AW handshake at edge N -> AWREADY=0, WREADY=1 from N+1.
- Last W beat at edge M -> WREADY=0, BVALID=1 from M+1; held with stable BID/BRESP until BREADY; AWREADY=1 cycle after B handshake.
- AR handshake at edge N -> RVALID=1 with first-beat data from N+1 (registered read). Next beat data presented cycle after each handshake; RDATA/RLAST stable while RVALID&!RREADY.
- After final R handshake: RVALID=RLAST=0, ARREADY=1 next cycle.
- Only one outstanding transaction per direction; AWREADY/ARREADY low while busy.

## Structure
- Shared package axi_pkg: burst encodings (FIXED=00, INCR=01, WRAP=10), response codes (OKAY=00, EXOKAY=01, SLVERR=10, DECERR=11), FSM state enums, next-address function.
- One sub-module natural: axi_mem_ram (byte-enabled write port, registered read port).

## Test plan
- Reset 10 cycles -> all outputs 0; cycle after release AWREADY=ARREADY=1.
- INCR write addr 0x0000, LEN=7, SIZE=2, WSTRB=1111, 8 random words, ID=0xA -> BVALID with BID=0xA, BRESP=00; INCR read same params -> 8 beats match, RLAST only on beat 7, RRESP=00.
- Repeat at 0x00F0, 0x7FF8 and 0xFFE0 -> data round-trips; INCR burst at 0xFFF8 wraps to 0x0000.
- Write WSTRB=0101 over known 0xFFFFFFFF -> readback 0xFF??FF?? with only lanes 0 and 2 updated.
- WRAP burst addr 0x0018, LEN=3, SIZE=2 -> beats at 0x18,0x1C,0x10,0x14; FIXED LEN=3 -> last write wins at single word.
- AWSIZE=3 or AWBURST=11 -> BRESP=10, memory unchanged; RREADY held low 3 cycles mid-read -> RDATA/RLAST stable.
